// File: rtl/data_memory.sv
// Block-organised data memory behind a cache controller.
// 64 blocks of 4 bytes; every request moves one whole block and takes
// LATENCY clock cycles, signalled to the requester through busywait.
module data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // The counter runs LATENCY-1 down to 0, so the access lands on the
    // LATENCY-th edge after the sample edge.
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    logic [31:0] mem [0:63];

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic [3:0]  counter_next;
    logic [5:0]  addr_q;
    logic [5:0]  addr_next;
    logic [31:0] wdata_q;
    logic [31:0] wdata_next;
    logic        is_write_q;
    logic        is_write_next;
    logic        busy_next;
    logic [31:0] rdata_next;
    logic        mem_we;

    // Next-state and next-output logic; a write wins over a read when both are requested.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        addr_next     = addr_q;
        wdata_next    = wdata_q;
        is_write_next = is_write_q;
        busy_next     = busywait;
        rdata_next    = readdata;
        mem_we        = 1'b0;
        case (state)
            IDLE: begin
                if (read || write) begin
                    addr_next     = address;
                    wdata_next    = writedata;
                    is_write_next = write;
                    busy_next     = 1'b1;
                    counter_next  = COUNT_LOAD;
                    state_next    = ACCESS;
                end else begin
                    busy_next = 1'b0;
                end
            end
            ACCESS: begin
                if (counter != 4'd0) begin
                    counter_next = counter - 4'd1;
                end else begin
                    if (is_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_next = mem[addr_q];
                    end
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Control state and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= 4'd0;
            addr_q     <= 6'd0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            busywait   <= 1'b0;
            readdata   <= 32'd0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            is_write_q <= is_write_next;
            busywait   <= busy_next;
            readdata   <= rdata_next;
        end
    end

    // Storage array; deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Two instances share the same request inputs: one built with the default
// LATENCY of 5 and one with LATENCY of 1.
module tb_data_memory;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata5;
    logic        busy5;
    logic [31:0] readdata1;
    logic        busy1;

    int checks   = 0;
    int failures = 0;
    int cyc5;
    int cyc1;

    data_memory #(.LATENCY(5)) dut5 (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata5),
        .busywait  (busy5)
    );

    data_memory #(.LATENCY(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata1),
        .busywait  (busy1)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one request at a negedge, drops it (and scrambles address/data)
    // after the sample edge, then counts busywait-high negedges per instance.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [5:0] addr,
                                 input logic [31:0] data, output int c5, output int c1);
        read      = rd;
        write     = wr;
        address   = addr;
        writedata = data;
        @(posedge clock);
        @(negedge clock);
        read      = 1'b0;
        write     = 1'b0;
        address   = ~addr;
        writedata = ~data;
        c5 = 0;
        c1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy5) c5++;
            if (busy1) c1++;
            if (!busy5 && !busy1) break;
            @(negedge clock);
        end
    endtask

    initial begin
        reset     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 6'd0;
        writedata = 32'd0;
        #1;
        checkOutput("rst_busy5", 32'(busy5), 32'd0);
        checkOutput("rst_rdata5", readdata5, 32'h0);
        checkOutput("rst_busy1", 32'(busy1), 32'd0);
        checkOutput("rst_rdata1", readdata1, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Preload blocks used later
        applyStimulus(1'b0, 1'b1, 6'h00, 32'hA5A5A5A5, cyc5, cyc1);
        checkOutput("w00_cyc5", 32'(cyc5), 32'd5);
        checkOutput("w00_cyc1", 32'(cyc1), 32'd1);
        applyStimulus(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, cyc5, cyc1);
        checkOutput("w05_cyc5", 32'(cyc5), 32'd5);
        applyStimulus(1'b0, 1'b1, 6'h06, 32'h12345678, cyc5, cyc1);

        // Write then read back
        applyStimulus(1'b1, 1'b0, 6'h05, 32'h0, cyc5, cyc1);
        checkOutput("r05_cyc5", 32'(cyc5), 32'd5);
        checkOutput("r05_cyc1", 32'(cyc1), 32'd1);
        checkOutput("r05_data5", readdata5, 32'hDEADBEEF);
        checkOutput("r05_data1", readdata1, 32'hDEADBEEF);

        // Idle: readdata holds, busywait stays low
        repeat (3) @(negedge clock);
        checkOutput("idle_busy5", 32'(busy5), 32'd0);
        checkOutput("idle_data5", readdata5, 32'hDEADBEEF);

        // Write-back then fetch with a single idle sample edge between
        applyStimulus(1'b0, 1'b1, 6'h3F, 32'h11223344, cyc5, cyc1);
        checkOutput("wb3f_cyc5", 32'(cyc5), 32'd5);
        checkOutput("wb3f_gap_busy5", 32'(busy5), 32'd0);
        applyStimulus(1'b1, 1'b0, 6'h00, 32'h0, cyc5, cyc1);
        checkOutput("f00_cyc5", 32'(cyc5), 32'd5);
        checkOutput("f00_data5", readdata5, 32'hA5A5A5A5);
        checkOutput("f00_data1", readdata1, 32'hA5A5A5A5);

        // Address changes mid-operation do not redirect the read
        read    = 1'b1;
        address = 6'h05;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        @(negedge clock);
        address   = 6'h06;
        writedata = 32'hFFFFFFFF;
        cyc5 = 1;
        for (int i = 0; i < 40 && busy5; i++) @(negedge clock);
        checkOutput("mid_busy5_done", 32'(busy5), 32'd0);
        checkOutput("mid_data5", readdata5, 32'hDEADBEEF);
        checkOutput("mid_data1", readdata1, 32'hDEADBEEF);

        // Simultaneous read and write: write only, readdata untouched
        applyStimulus(1'b1, 1'b1, 6'h10, 32'hCAFEF00D, cyc5, cyc1);
        checkOutput("rw10_cyc5", 32'(cyc5), 32'd5);
        checkOutput("rw10_hold5", readdata5, 32'hDEADBEEF);
        checkOutput("rw10_hold1", readdata1, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 6'h10, 32'h0, cyc5, cyc1);
        checkOutput("r10_data5", readdata5, 32'hCAFEF00D);
        checkOutput("r10_data1", readdata1, 32'hCAFEF00D);

        // Earlier write-back actually landed
        applyStimulus(1'b1, 1'b0, 6'h3F, 32'h0, cyc5, cyc1);
        checkOutput("r3f_data5", readdata5, 32'h11223344);

        // Reset in the middle of a write aborts it
        write     = 1'b1;
        address   = 6'h05;
        writedata = 32'h0BADF00D;
        @(posedge clock);
        @(negedge clock);
        write = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("pre_rst_busy5", 32'(busy5), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mrst_busy5", 32'(busy5), 32'd0);
        checkOutput("mrst_data5", readdata5, 32'h0);
        checkOutput("mrst_data1", readdata1, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("post_rst_busy5", 32'(busy5), 32'd0);
        applyStimulus(1'b1, 1'b0, 6'h05, 32'h0, cyc5, cyc1);
        checkOutput("post_r05_cyc5", 32'(cyc5), 32'd5);
        checkOutput("post_r05_data5", readdata5, 32'hDEADBEEF);
        checkOutput("post_r05_data1", readdata1, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter: LATENCY, 5, clock cycles from request sample to completion; legal range 1..15.
REQ-002 SHALL have port: clock  input  1  single system clock; all sequential logic on posedge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: read  input  1  block read request from the cache controller.
REQ-005 SHALL have port: write  input  1  block write-back request from the cache controller.
REQ-006 SHALL have port: address  input  6  block address; byte address = {address, 2'b00}.
REQ-007 SHALL have port: writedata  input  32  block to write; bits [8k+7:8k] = byte offset k.
REQ-008 SHALL have port: readdata  output  32  fetched block; same byte packing as writedata.
REQ-009 SHALL have port: busywait  output  1  high while a request is in progress.

Function
REQ-010 SHALL store 256 bytes organised as 64 blocks of 4 bytes; each access moves one full block.
REQ-011 SHALL implement a two-state FSM, IDLE and ACCESS, with state and all outputs registered on posedge clock.
REQ-012 In IDLE, on a posedge with read or write high, SHALL latch address, writedata and operation type, set busywait=1, load a 4-bit counter with LATENCY-1, and enter ACCESS.
REQ-013 In IDLE with both read and write low, SHALL hold busywait=0 and readdata unchanged.
REQ-014 In ACCESS with counter non-zero, SHALL decrement the counter by 1 per posedge and ignore all request inputs.
REQ-015 In ACCESS with counter zero, a read SHALL load readdata with the latched block on that posedge.
REQ-016 In ACCESS with counter zero, a write SHALL store the latched writedata into the latched block on that posedge.
REQ-017 In ACCESS with counter zero, SHALL clear busywait and return to IDLE on the same posedge as REQ-015/REQ-016.
REQ-018 busywait SHALL be high for exactly LATENCY cycles per request: it rises after sample edge E0 and falls after edge E0+LATENCY.
REQ-019 readdata SHALL be valid no later than the falling edge of busywait and SHALL hold until the next read completes.
REQ-020 If read and write are both high when sampled, SHALL perform the write and SHALL NOT perform a read.
REQ-021 Changes on address, writedata, read or write during ACCESS SHALL NOT affect the operation in progress.
REQ-022 A request still high at the posedge after busywait falls SHALL be treated as a new request; the requester drops it on negedge busywait.
REQ-023 Back-to-back requests (write-back then fetch) SHALL each take LATENCY cycles, with one IDLE sample edge between them.
REQ-024 LATENCY=1 SHALL give busywait high for exactly one cycle, with the access performed on the edge following the sample edge.

Reset
REQ-025 reset low SHALL immediately force state=IDLE, busywait=0, readdata=32'h0 and counter=0, independent of clock.
REQ-026 reset asserted during ACCESS SHALL abort the operation; a pending write SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be altered by reset.
REQ-028 After reset deasserts, the first posedge with a request SHALL start a normal access per REQ-012.

Verification
REQ-029 Write then read: write=1, address=6'h05, writedata=32'hDEADBEEF; then read=1, address=6'h05 -> each busywait pulse lasts 5 cycles; readdata=32'hDEADBEEF.
REQ-030 Write-back then fetch: write to 6'h3F with data 32'h11223344; on negedge busywait raise read to 6'h00 (previously 32'hA5A5A5A5) -> two 5-cycle busywait pulses with one IDLE edge between; readdata=32'hA5A5A5A5.
REQ-031 Mid-operation change: read 6'h05 sampled, then address switched to 6'h06 at cycle 2 -> readdata=32'hDEADBEEF (block 6'h05).
REQ-032 Simultaneous request: read=write=1, address=6'h10, writedata=32'hCAFEF00D -> write performed; a following read of 6'h10 returns 32'hCAFEF00D.
REQ-033 Reset mid-write: write 32'h0BADF00D to 6'h05, reset low at cycle 3 -> busywait=0 and readdata=0 immediately; a later read of 6'h05 returns 32'hDEADBEEF.
REQ-034 LATENCY=1 build: read 6'h05 -> busywait high exactly 1 cycle; readdata=32'hDEADBEEF.
